// File: rtl/uart_tx_if.sv
// Byte request handshake between a packet formatter and the UART transmitter.
// Latency: none; this file only carries wires.
// Backpressure: done low means the transmitter ignores send. send is not queued.
// Signals:
//   send         requester -> uart  level request to transmit byte_to_send
//   byte_to_send requester -> uart  data byte, taken on the accepting edge only
//   done         uart -> requester  idle and able to accept this cycle
interface uart_tx_if;
  logic       send;
  logic [7:0] byte_to_send;
  logic       done;

  modport master (output send, output byte_to_send, input done);
  modport slave  (input send, input byte_to_send, output done);
endinterface

// File: rtl/uart_tx.sv
// Transmit-only UART: serializes one byte into an 8N1 frame (8E1 with UART_TX_PARITY_EN).
// Latency: start bit appears the cycle after the accepting edge; frame lasts 10 (11) x clocks_per_bit cycles.
// Backpressure: done = idle && !send; a send raised while busy is dropped, not queued.
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset; aborts any frame and forces pin high
//   bus      uart_tx_if.slave (send / byte_to_send / done)
//   pin      registered serial output, idle high
// Optional macro: UART_TX_PARITY_EN inserts an even parity bit between bit7 and stop.
module uart_tx #(
  parameter int unsigned clocks_per_bit = 1
) (
  input  logic     clock,
  input  logic     reset_n,
  uart_tx_if.slave bus,
  output logic     pin
);

  // Counter counts down from clocks_per_bit-1 to 0, so each bit lasts clocks_per_bit cycles.
  localparam logic [15:0] BitReload = 16'(clocks_per_bit - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        pin_q, pin_d;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic bit_end;
  assign bit_end = (cnt_q == 16'd0);

  // Gating done with send keeps a same-edge requester from seeing done twice per byte.
  assign bus.done = (state_q == IDLE) && !bus.send;
  assign pin      = pin_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    pin_d   = pin_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        pin_d = 1'b1;
        if (bus.send) begin
          state_d = START;
          shreg_d = bus.byte_to_send;
          cnt_d   = BitReload;
          idx_d   = 3'd0;
          pin_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^bus.byte_to_send;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = BitReload;
          pin_d   = shreg_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = BitReload;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            pin_d   = par_q;
`else
            state_d = STOP;
            pin_d   = 1'b1;
`endif
          end else begin
            // shreg_q[0] is the bit on the pin now; [1] goes out next.
            idx_d   = idx_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            pin_d   = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = BitReload;
          pin_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          pin_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        pin_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shreg_q <= 8'd0;
      pin_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      pin_q   <= pin_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance at 4 clocks/bit, one at 1 clock/bit.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int STOP_PH = NBITS - 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic pin4, pin1;

  uart_tx_if if4();
  uart_tx_if if1();

  uart_tx #(.clocks_per_bit(4)) u_dut4 (.clock(clock), .reset_n(reset_n), .bus(if4), .pin(pin4));
  uart_tx #(.clocks_per_bit(1)) u_dut1 (.clock(clock), .reset_n(reset_n), .bus(if1), .pin(pin1));

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic test_reset();
    if4.send = 1'b0; if4.byte_to_send = 8'h00;
    if1.send = 1'b0; if1.byte_to_send = 8'h00;
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++; if (pin4 !== 1'b1 || pin1 !== 1'b1) begin bad++; $display("FAIL rst_pin cyc=%0d pin4=%b pin1=%b expected 1", i, pin4, pin1); end
      total++; if (if4.done !== 1'b1 || if1.done !== 1'b1) begin bad++; $display("FAIL rst_done cyc=%0d done4=%b done1=%b expected 1", i, if4.done, if1.done); end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++; if (pin4 !== 1'b1 || pin1 !== 1'b1) begin bad++; $display("FAIL idle_pin cyc=%0d pin4=%b pin1=%b expected 1", i, pin4, pin1); end
      total++; if (if4.done !== 1'b1 || if1.done !== 1'b1) begin bad++; $display("FAIL idle_done cyc=%0d done4=%b done1=%b expected 1", i, if4.done, if1.done); end
    end
  endtask

  // One frame on the 4-clocks/bit instance, optionally poking send mid-frame.
  task automatic frame_4(input logic [7:0] data, input bit inject, input string tag);
    logic ex [0:10];
    ex[0] = 1'b0;
    for (int i = 0; i < 8; i++) ex[1+i] = data[i];
`ifdef UART_TX_PARITY_EN
    ex[9] = ^data;
`endif
    ex[NBITS-1] = 1'b1;

    @(negedge clock);
    if4.send = 1'b1; if4.byte_to_send = data;
    #1;
    total++; if (if4.done !== 1'b0) begin bad++; $display("FAIL %s_done_req done=%b expected 0", tag, if4.done); end
    @(negedge clock);
    if4.send = 1'b0; if4.byte_to_send = 8'h00;
    for (int k = 0; k < NBITS*4; k++) begin
      total++; if (pin4 !== ex[k/4]) begin bad++; $display("FAIL %s_pin k=%0d pin=%b expected %b", tag, k, pin4, ex[k/4]); end
      total++; if (if4.done !== 1'b0) begin bad++; $display("FAIL %s_busy k=%0d done=%b expected 0", tag, k, if4.done); end
      if (inject && k == 9)  begin if4.send = 1'b1; if4.byte_to_send = 8'h3C; end
      if (inject && k == 10) begin if4.send = 1'b0; if4.byte_to_send = 8'h00; end
      @(negedge clock);
    end
    for (int k = 0; k < 20; k++) begin
      total++; if (pin4 !== 1'b1 || if4.done !== 1'b1) begin bad++; $display("FAIL %s_after k=%0d pin=%b done=%b expected 1/1", tag, k, pin4, if4.done); end
      @(negedge clock);
    end
  endtask

  task automatic test_single_byte();
    frame_4(8'hA5, 1'b0, "single");
  endtask

  task automatic test_busy_ignore();
    frame_4(8'hA5, 1'b1, "busy");
  endtask

  task automatic test_back_to_back();
    logic [7:0] txb [0:2];
    logic [7:0] rxb [0:2];
    logic [7:0] rx_sh;
    int sent = 0, rx_n = 0, rx_ph = 0, gap = 0;
    txb[0] = 8'hFF; txb[1] = 8'hFF; txb[2] = 8'hFD;
    rxb[0] = 8'h00; rxb[1] = 8'h00; rxb[2] = 8'h00;
    rx_sh = 8'h00;
    if1.send = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clock);
      if (rx_ph == 0) begin
        if (pin1 === 1'b0) begin
          rx_ph = 1;
          if (rx_n > 0) begin
            total++; if (gap > 1) begin bad++; $display("FAIL b2b_gap frame=%0d gap=%0d expected <=1", rx_n, gap); end
          end
        end else begin
          gap++;
        end
      end else if (rx_ph <= 8) begin
        rx_sh = {pin1, rx_sh[7:1]};
        rx_ph++;
`ifdef UART_TX_PARITY_EN
      end else if (rx_ph == 9) begin
        total++; if (pin1 !== ^rx_sh) begin bad++; $display("FAIL b2b_par frame=%0d got=%b expected %b", rx_n, pin1, ^rx_sh); end
        rx_ph++;
`endif
      end else begin
        total++; if (pin1 !== 1'b1) begin bad++; $display("FAIL b2b_stop frame=%0d got=%b expected 1", rx_n, pin1); end
        if (rx_n < 3) rxb[rx_n] = rx_sh;
        rx_n++;
        rx_ph = 0;
        gap = 0;
      end
      if (if1.send) begin
        if1.send = 1'b0;
      end else if (if1.done === 1'b1 && sent < 3) begin
        if1.send = 1'b1;
        if1.byte_to_send = txb[sent];
        sent++;
      end
    end
    if1.send = 1'b0;
    total++; if (rx_n != 3) begin bad++; $display("FAIL b2b_count frames=%0d expected 3", rx_n); end
    for (int i = 0; i < 3; i++) begin
      total++; if (rxb[i] !== txb[i]) begin bad++; $display("FAIL b2b_byte%0d got=%h expected %h", i, rxb[i], txb[i]); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    if4.send = 1'b1; if4.byte_to_send = 8'h55;
    @(negedge clock);
    if4.send = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clock);
    // k=10 lies in data bit1 of 0x55, which is 0
    total++; if (pin4 !== 1'b0) begin bad++; $display("FAIL mid_in_data pin=%b expected 0", pin4); end
    reset_n = 1'b0;
    #1;
    total++; if (pin4 !== 1'b1) begin bad++; $display("FAIL mid_rst_pin pin=%b expected 1", pin4); end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    total++; if (if4.done !== 1'b1) begin bad++; $display("FAIL mid_rel_done done=%b expected 1", if4.done); end
    for (int k = 0; k < 48; k++) begin
      @(negedge clock);
      total++; if (pin4 !== 1'b1) begin bad++; $display("FAIL mid_no_resume k=%0d pin=%b expected 1", k, pin4); end
    end
    frame_4(8'h0F, 1'b0, "post_rst");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    frame_4(8'hA5, 1'b0, "par_a5");
    frame_4(8'h01, 1'b0, "par_01");
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
